// File: rtl/bcd_disp_pkg.sv
// Shared definitions for the BCD 7-segment display path.
// Contents: segment encodings ({g,f,e,d,c,b,a}, active-high), digit count,
// nibble field positions within the packed 3-digit BCD word, the digit-scan
// state type, and a helper that flags non-decimal nibbles.
package bcd_disp_pkg;

  localparam int unsigned NUM_DIGITS = 3;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned UNITS_LSB  = 0;
  localparam int unsigned TENS_LSB   = 4;
  localparam int unsigned HUNDS_LSB  = 8;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  typedef enum logic [1:0] {
    DIG_UNITS = 2'd0,
    DIG_TENS  = 2'd1,
    DIG_HUNDS = 2'd2
  } digit_e;

  function automatic logic nib_invalid(input logic [3:0] nib);
    return (nib > 4'd9);
  endfunction

endpackage

// File: rtl/bcd_7seg_scan_if.sv
// Display bus between the BCD producer side and the scanned 7-segment driver.
// master: drives bcd_in/load/blank_lz, observes the display outputs.
// slave : the scan driver; receives the BCD word, drives seg/an/frame_done/bcd_err.
interface bcd_7seg_scan_if;
  import bcd_disp_pkg::*;

  logic [NUM_DIGITS*NIB_W-1:0] bcd_in;
  logic                        load;
  logic                        blank_lz;
  logic [6:0]                  seg;
  logic [NUM_DIGITS-1:0]       an;
  logic                        frame_done;
  logic                        bcd_err;

  modport master (
    output bcd_in, load, blank_lz,
    input  seg, an, frame_done, bcd_err
  );

  modport slave (
    input  bcd_in, load, blank_lz,
    output seg, an, frame_done, bcd_err
  );

endinterface

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to 7-segment decoder.
// i_nibble : 4-bit BCD digit
// o_seg    : segments {g,f,e,d,c,b,a}, active-high; 10..15 show a dash
module bcd_to_7seg (
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);
  import bcd_disp_pkg::*;

  always_comb begin
    o_seg = SEG_DASH;
    case (i_nibble)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_7seg_scan.sv
// Time-multiplexed 3-digit 7-segment driver for a packed BCD value.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - slave modport: bcd_in[11:0], load, blank_lz in;
//          seg[6:0], an[2:0] (bit0 = units), frame_done, bcd_err out (all registered)
// Loads land in a pending buffer that is copied to the displayed value only
// at the hundreds->units wrap, so a frame never mixes old and new digits.
module bcd_7seg_scan #(
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned NUM_DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  bcd_7seg_scan_if.slave        bus
);
  import bcd_disp_pkg::*;

  localparam int unsigned    CNT_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam digit_e         LAST_DIGIT = digit_e'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] r_div_cnt;
  digit_e           r_digit;
  digit_e           w_digit_nxt;
  logic [11:0]      r_disp;
  logic [11:0]      r_pending;
  logic             r_pending_valid;
  logic [6:0]       r_seg;
  logic [2:0]       r_an;
  logic             r_frame_done;
  logic             r_bcd_err;

  logic             w_div_wrap;
  logic             w_frame_wrap;
  logic [3:0]       w_nib;
  logic [2:0]       w_an;
  logic             w_blank;
  logic [6:0]       w_dec_seg;
  logic             w_err;
  logic             w_hund_zero;
  logic             w_tens_zero;

  assign w_div_wrap   = (r_div_cnt == CNT_LAST);
  assign w_frame_wrap = w_div_wrap && (r_digit == LAST_DIGIT);

  // Digit scan state
  always_ff @(posedge clk) begin
    if (rst) r_digit <= DIG_UNITS;
    else     r_digit <= w_digit_nxt;
  end

  always_comb begin
    w_digit_nxt = r_digit;
    if (w_div_wrap) begin
      case (r_digit)
        DIG_UNITS: w_digit_nxt = DIG_TENS;
        DIG_TENS:  w_digit_nxt = DIG_HUNDS;
        default:   w_digit_nxt = DIG_UNITS;
      endcase
    end
  end

  // Digit select and blanking; a non-decimal nibble never counts as zero.
  assign w_hund_zero = (r_disp[HUNDS_LSB +: NIB_W] == 4'd0);
  assign w_tens_zero = (r_disp[TENS_LSB  +: NIB_W] == 4'd0);

  always_comb begin
    w_nib   = r_disp[UNITS_LSB +: NIB_W];
    w_an    = 3'b001;
    w_blank = 1'b0;
    case (r_digit)
      DIG_TENS: begin
        w_nib   = r_disp[TENS_LSB +: NIB_W];
        w_an    = 3'b010;
        w_blank = bus.blank_lz && w_hund_zero && w_tens_zero;
      end
      DIG_HUNDS: begin
        w_nib   = r_disp[HUNDS_LSB +: NIB_W];
        w_an    = 3'b100;
        w_blank = bus.blank_lz && w_hund_zero;
      end
      default: ;
    endcase
  end

  assign w_err = nib_invalid(r_disp[HUNDS_LSB +: NIB_W]) |
                 nib_invalid(r_disp[TENS_LSB  +: NIB_W]) |
                 nib_invalid(r_disp[UNITS_LSB +: NIB_W]);

  bcd_to_7seg u_dec (
    .i_nibble (w_nib),
    .o_seg    (w_dec_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt       <= '0;
      r_disp          <= '0;
      r_pending       <= '0;
      r_pending_valid <= 1'b0;
      r_seg           <= '0;
      r_an            <= '0;
      r_frame_done    <= 1'b0;
      r_bcd_err       <= 1'b0;
    end else begin
      r_div_cnt <= w_div_wrap ? '0 : r_div_cnt + 1'b1;
      if (bus.load)
        r_pending <= bus.bcd_in;
      // Swap reads the pre-edge pending word; a coincident load refills it.
      if (w_frame_wrap && r_pending_valid)
        r_disp <= r_pending;
      if (bus.load)
        r_pending_valid <= 1'b1;
      else if (w_frame_wrap)
        r_pending_valid <= 1'b0;
      r_frame_done <= w_frame_wrap;
      r_an         <= w_an;
      r_seg        <= w_blank ? SEG_OFF : w_dec_seg;
      r_bcd_err    <= w_err;
    end
  end

  assign bus.seg        = r_seg;
  assign bus.an         = r_an;
  assign bus.frame_done = r_frame_done;
  assign bus.bcd_err    = r_bcd_err;

endmodule

// File: tb/tb_bcd_7seg_scan.sv
module tb_bcd_7seg_scan;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   frame_no;

  bcd_7seg_scan_if u_bus ();

  bcd_7seg_scan #(.SCAN_DIV(4), .NUM_DIGITS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] bcd;
    logic        blank;
    logic [6:0]  u;
    logic [6:0]  t;
    logic [6:0]  h;
    logic        err;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s frame=%0d got=%0h expected=%0h", name, frame_no, act, exp);
    end
  endtask

  // Checks one full frame (12 cycles) of scan output; es = {hundreds,tens,units}.
  // Up to three loads may be injected at given slots; nb is applied so that it
  // takes effect from the first digit of the following frame.
  task automatic check_frame(input logic [20:0] es, input logic ee,
                             input int s0, input logic [11:0] v0,
                             input int s1, input logic [11:0] v1,
                             input int s2, input logic [11:0] v2,
                             input logic nb);
    logic [2:0] exp_an;
    logic [6:0] exp_seg;
    for (int slot = 0; slot < 12; slot++) begin
      @(negedge clk);
      exp_an  = 3'b001 << (slot / 4);
      exp_seg = es[(slot / 4) * 7 +: 7];
      chk("an", 32'(u_bus.an), 32'(exp_an));
      chk("seg", 32'(u_bus.seg), 32'(exp_seg));
      chk("bcd_err", 32'(u_bus.bcd_err), 32'(ee));
      chk("frame_done", 32'(u_bus.frame_done), 32'(slot == 11));
      u_bus.load = 1'b0;
      if (slot == s0) begin u_bus.load = 1'b1; u_bus.bcd_in = v0; end
      if (slot == s1) begin u_bus.load = 1'b1; u_bus.bcd_in = v1; end
      if (slot == s2) begin u_bus.load = 1'b1; u_bus.bcd_in = v2; end
      if (slot == 11) u_bus.blank_lz = nb;
    end
    frame_no++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [20:0] prev;
    logic        perr;

    n_tests  = 0;
    n_fail   = 0;
    frame_no = 0;

    tbl[0]  = '{12'h007, 1'b1, 7'h07, 7'h00, 7'h00, 1'b0};
    tbl[1]  = '{12'h007, 1'b0, 7'h07, 7'h3F, 7'h3F, 1'b0};
    tbl[2]  = '{12'h105, 1'b1, 7'h6D, 7'h3F, 7'h06, 1'b0};
    tbl[3]  = '{12'h1A3, 1'b1, 7'h4F, 7'h40, 7'h06, 1'b1};
    tbl[4]  = '{12'h123, 1'b1, 7'h4F, 7'h5B, 7'h06, 1'b0};
    tbl[5]  = '{12'h000, 1'b0, 7'h3F, 7'h3F, 7'h3F, 1'b0};
    tbl[6]  = '{12'h0A0, 1'b1, 7'h3F, 7'h40, 7'h00, 1'b1};
    tbl[7]  = '{12'h999, 1'b1, 7'h6F, 7'h6F, 7'h6F, 1'b0};
    tbl[8]  = '{12'hF00, 1'b1, 7'h3F, 7'h3F, 7'h40, 1'b1};
    tbl[9]  = '{12'h060, 1'b1, 7'h3F, 7'h7D, 7'h00, 1'b0};
    tbl[10] = '{12'h048, 1'b1, 7'h7F, 7'h66, 7'h00, 1'b0};

    rst            = 1'b1;
    u_bus.load     = 1'b0;
    u_bus.bcd_in   = '0;
    u_bus.blank_lz = 1'b1;

    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_seg", 32'(u_bus.seg), 32'h0);
      chk("rst_an", 32'(u_bus.an), 32'h0);
      chk("rst_frame_done", 32'(u_bus.frame_done), 32'h0);
      chk("rst_bcd_err", 32'(u_bus.bcd_err), 32'h0);
    end
    rst = 1'b0;

    // Idle frame with 0x000 blanked; load 0x255 while tens is lit.
    check_frame({7'h00, 7'h00, 7'h3F}, 1'b0, 4, 12'h255, -1, '0, -1, '0, 1'b1);
    prev = {7'h5B, 7'h6D, 7'h6D};
    perr = 1'b0;

    for (int i = 0; i < 11; i++) begin
      check_frame(prev, perr, 5, tbl[i].bcd, -1, '0, -1, '0, tbl[i].blank);
      prev = {tbl[i].h, tbl[i].t, tbl[i].u};
      perr = tbl[i].err;
    end

    // Two loads in one frame plus a load on the swap edge.
    check_frame(prev, perr, 2, 12'h111, 6, 12'h222, 10, 12'h333, 1'b1);
    check_frame({7'h5B, 7'h5B, 7'h5B}, 1'b0, -1, '0, -1, '0, -1, '0, 1'b1);
    check_frame({7'h4F, 7'h4F, 7'h4F}, 1'b0, 5, 12'h255, -1, '0, -1, '0, 1'b1);

    // Frame showing 0x255; queue 0x999 then reset while tens is lit.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("pre_rst_an", 32'(u_bus.an), 32'h1);
      chk("pre_rst_seg", 32'(u_bus.seg), 32'h6D);
    end
    u_bus.load   = 1'b1;
    u_bus.bcd_in = 12'h999;
    @(negedge clk);
    chk("pre_rst_an2", 32'(u_bus.an), 32'h2);
    chk("pre_rst_seg2", 32'(u_bus.seg), 32'h6D);
    u_bus.load = 1'b0;
    rst        = 1'b1;
    @(negedge clk);
    chk("mid_rst_seg", 32'(u_bus.seg), 32'h0);
    chk("mid_rst_an", 32'(u_bus.an), 32'h0);
    chk("mid_rst_frame_done", 32'(u_bus.frame_done), 32'h0);
    chk("mid_rst_bcd_err", 32'(u_bus.bcd_err), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    frame_no++;

    // Pending 0x999 must have been discarded by the reset.
    check_frame({7'h00, 7'h00, 7'h3F}, 1'b0, -1, '0, -1, '0, -1, '0, 1'b1);
    check_frame({7'h00, 7'h00, 7'h3F}, 1'b0, -1, '0, -1, '0, -1, '0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
